// File: rtl/lfsr_scrambler_gen.sv
// Additive scrambler/descrambler around a Galois LFSR with shadowed seed, frame restart and periodic reseed.
// Optional register readback is compiled in by defining LFSR_SCRAMBLER_READBACK_EN.
module lfsr_scrambler_gen #(
  parameter int unsigned           POLY_WIDTH    = 212,
  parameter int unsigned           NUM_OF_STEPS  = 12,
  parameter logic [POLY_WIDTH-1:0] TAP_MASK      = (POLY_WIDTH'(1) << 8'd181) | (POLY_WIDTH'(1) << 8'd158) |
                                                   (POLY_WIDTH'(1) << 8'd127) | (POLY_WIDTH'(1) << 8'd92)  |
                                                   (POLY_WIDTH'(1) << 8'd83)  | POLY_WIDTH'(1),
  parameter logic [POLY_WIDTH-1:0] SEED_INIT     = POLY_WIDTH'(1),
  parameter logic [11:0]           BASE_ADDR     = 12'h0de,
  parameter logic [15:0]           RESEED_PERIOD = 16'd1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write,
  input  logic                    read,
  input  logic [11:0]             addr,
  input  logic [31:0]             lfsrdin,
  output logic [31:0]             rdata,
  input  logic                    frame_start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NUM_OF_STEPS-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NUM_OF_STEPS-1:0] m_data,
  output logic [POLY_WIDTH-1:0]   dout
);

  localparam int unsigned W         = POLY_WIDTH;
  localparam int unsigned N         = NUM_OF_STEPS;
  localparam int unsigned NUM_WORDS = (W + 31) / 32;
  localparam int unsigned PAD_W     = NUM_WORDS * 32;
  localparam logic [11:0] TOP_OFF   = 12'(NUM_WORDS - 1);
  localparam logic [11:0] CTRL_OFF  = 12'(NUM_WORDS);
  localparam logic [11:0] BEAT_OFF  = 12'(NUM_WORDS + 1);

  logic [W-1:0]     state_q, state_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic [W-1:0]     adv_s;
  logic [PAD_W-1:0] shadow_ext_s, shadow_pad_s;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [N-1:0]     m_data_q, m_data_d, ks_s;
  logic [11:0]      offset_s;
  logic             seed_wr_s, commit_s, ctrl_wr_s, accept_s, reseed_s, bypass_s;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    lfsr_step = {s[W-2:0], 1'b0} ^ ({W{s[W-1]}} & TAP_MASK);
  endfunction

  assign s_ready = !m_valid_q || m_ready;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign dout    = state_q;

  // Register decode and stream handshake qualifiers
  always_comb begin
    offset_s  = addr - BASE_ADDR;
    seed_wr_s = write && (offset_s < CTRL_OFF);
    commit_s  = write && (offset_s == TOP_OFF);
    ctrl_wr_s = write && (offset_s == CTRL_OFF);
    bypass_s  = ctrl_q[0];
    accept_s  = s_valid && s_ready;
    reseed_s  = accept_s && ctrl_q[1] && (cnt_q == (RESEED_PERIOD - 16'd1));
  end

  // Merge a seed word into the shadow; bits above W-1 fall off the top word
  always_comb begin
    shadow_ext_s          = '0;
    shadow_ext_s[W-1:0]   = shadow_q;
    shadow_pad_s          = shadow_ext_s;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (seed_wr_s && (offset_s == 12'(k))) shadow_pad_s[k*32 +: 32] = lfsrdin;
      else                                    shadow_pad_s[k*32 +: 32] = shadow_ext_s[k*32 +: 32];
    end
    shadow_d = shadow_pad_s[W-1:0];
  end

  // Keystream bit j is the MSB before step j
  always_comb begin
    adv_s = state_q;
    ks_s  = '0;
    for (int j = 0; j < N; j++) begin
      ks_s[j] = adv_s[W-1];
      adv_s   = lfsr_step(adv_s);
    end
  end

  // Next-state selection: commit > frame_start > auto-reseed > advance > hold
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (commit_s)                    state_d = shadow_d;
    else if (frame_start)            state_d = shadow_q;
    else if (reseed_s && !bypass_s)  state_d = shadow_q;
    else if (accept_s && !bypass_s)  state_d = adv_s;
    else                             state_d = state_q;
    if (commit_s)      cnt_d = 16'd0;
    else if (reseed_s) cnt_d = 16'd0;
    else if (accept_s) cnt_d = cnt_q + 16'd1;
    else               cnt_d = cnt_q;
    if (ctrl_wr_s) ctrl_d = lfsrdin[1:0];
    else           ctrl_d = ctrl_q;
    if (accept_s) begin
      m_valid_d = 1'b1;
      m_data_d  = bypass_s ? s_data : (s_data ^ ks_s);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State, shadow, control, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SEED_INIT;
      shadow_q  <= SEED_INIT;
      ctrl_q    <= 2'd0;
      cnt_q     <= 16'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

`ifdef LFSR_SCRAMBLER_READBACK_EN
  logic [PAD_W-1:0] state_ext_s;
  logic [31:0]      rdata_d, rdata_q;

  // Readback mux: live state words, control bits, beat counter
  always_comb begin
    state_ext_s        = '0;
    state_ext_s[W-1:0] = state_q;
    rdata_d            = 32'd0;
    if (offset_s == CTRL_OFF) begin
      rdata_d = {30'd0, ctrl_q};
    end else if (offset_s == BEAT_OFF) begin
      rdata_d = {16'd0, cnt_q};
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (offset_s == 12'(k)) rdata_d = state_ext_s[k*32 +: 32];
        else                    rdata_d = rdata_d;
      end
    end
  end

  // Read data register holds until the next read
  always_ff @(posedge clk) begin
    if (!rst_n)    rdata_q <= 32'd0;
    else if (read) rdata_q <= rdata_d;
    else           rdata_q <= rdata_q;
  end

  assign rdata = rdata_q;
`else
  logic unused_read_s;
  assign unused_read_s = read;
  assign rdata         = 32'd0;
`endif

endmodule

// File: tb/tb_lfsr_scrambler_gen.sv
// Self-checking bench for lfsr_scrambler_gen: directed table, corner sequences, randomized run vs. a reference model.
module tb_lfsr_scrambler_gen;

  localparam int W = 212;
  localparam int N = 12;
  localparam logic [W-1:0] TAP  = (212'd1 << 8'd181) | (212'd1 << 8'd158) | (212'd1 << 8'd127) |
                                  (212'd1 << 8'd92)  | (212'd1 << 8'd83)  | 212'd1;
  localparam logic [W-1:0] SEED = 212'd1;
  localparam logic [W-1:0] SH   = (212'd1 << 8'd211) | 212'd1;

  logic          clk, rst_n, write, read, frame_start, s_valid, s_ready, m_valid, m_ready;
  logic [11:0]   addr;
  logic [31:0]   lfsrdin, rdata;
  logic [N-1:0]  s_data, m_data;
  logic [W-1:0]  dout;

  lfsr_scrambler_gen #(.RESEED_PERIOD(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .read(read), .addr(addr), .lfsrdin(lfsrdin),
    .rdata(rdata), .frame_start(frame_start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0]  m_st, m_sh;
  logic [1:0]    m_ctrl;
  logic [15:0]   m_cnt;
  logic          m_mv;
  logic [N-1:0]  m_md;
  logic [31:0]   m_rd;

  typedef struct {
    logic        wr;
    logic [11:0] a;
    logic [31:0] wd;
    logic        sv;
    logic [11:0] sd;
    logic        exp_mv;
    logic [11:0] exp_md;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_tick();
    logic [N-1:0]  ks;
    logic [W-1:0]  adv, sh_n, st_n;
    logic [223:0]  pad;
    logic [15:0]   cnt_n;
    logic [31:0]   rd_n;
    logic          acc, commit, reseed, byp;
    int            off;
    if (!rst_n) begin
      m_st = SEED; m_sh = SEED; m_ctrl = 2'd0; m_cnt = 16'd0;
      m_mv = 1'b0; m_md = '0; m_rd = 32'd0;
      return;
    end
    off = int'(addr) - 32'h0de;
    byp = m_ctrl[0];
    acc = s_valid && (!m_mv || m_ready);
    adv = m_st;
    for (int j = 0; j < N; j++) begin
      ks[j] = adv[W-1];
      adv   = {adv[W-2:0], 1'b0} ^ (adv[W-1] ? TAP : '0);
    end
    rd_n = m_rd;
`ifdef LFSR_SCRAMBLER_READBACK_EN
    pad = {12'd0, m_st};
    if (read) begin
      if (off >= 0 && off < 7) rd_n = pad[off*32 +: 32];
      else if (off == 7)       rd_n = {30'd0, m_ctrl};
      else if (off == 8)       rd_n = {16'd0, m_cnt};
      else                     rd_n = 32'd0;
    end
`endif
    sh_n   = m_sh;
    commit = 1'b0;
    if (write && off >= 0 && off < 7) begin
      pad = {12'd0, m_sh};
      pad[off*32 +: 32] = lfsrdin;
      sh_n   = pad[W-1:0];
      commit = (off == 6);
    end
    reseed = acc && m_ctrl[1] && (m_cnt == 16'd3);
    st_n = m_st;
    if (commit)                   st_n = sh_n;
    else if (frame_start)         st_n = m_sh;
    else if (!byp && reseed)      st_n = m_sh;
    else if (!byp && acc)         st_n = adv;
    cnt_n = m_cnt;
    if (commit)   cnt_n = 16'd0;
    else if (acc) cnt_n = reseed ? 16'd0 : m_cnt + 16'd1;
    if (acc) begin
      m_md = byp ? s_data : (s_data ^ ks);
      m_mv = 1'b1;
    end else if (m_ready) begin
      m_mv = 1'b0;
    end
    if (write && off == 7) m_ctrl = lfsrdin[1:0];
    m_st = st_n; m_sh = sh_n; m_cnt = cnt_n; m_rd = rd_n;
  endtask

  task automatic compare_all();
    chk("m_valid", m_valid, m_mv);
    chk("m_data",  m_data,  m_md);
    chk("s_ready", s_ready, !m_mv || m_ready);
    chk("dout",    dout,    m_st);
    chk("rdata",   rdata,   m_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
    compare_all();
  endtask

  task automatic idle();
    write = 1'b0; read = 1'b0; frame_start = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got;
    logic [11:0] held;

    tbl[0] = '{1'b0, 12'h000, 32'h0,        1'b1, 12'hABC, 1'b1, 12'hABC};
    tbl[1] = '{1'b0, 12'h000, 32'h0,        1'b0, 12'h000, 1'b0, 12'hABC};
    tbl[2] = '{1'b1, 12'h0e4, 32'h00080000, 1'b0, 12'h000, 1'b0, 12'hABC};
    tbl[3] = '{1'b0, 12'h000, 32'h0,        1'b1, 12'h000, 1'b1, 12'h001};
    tbl[4] = '{1'b0, 12'h000, 32'h0,        1'b1, 12'hFFF, 1'b1, 12'hFFF};

    rst_n = 1'b0; idle(); addr = 12'h0; lfsrdin = 32'h0; s_data = '0; m_ready = 1'b1;
    tick(); tick();
    chk("reset_dout", dout, SEED);
    chk("reset_s_ready", s_ready, 1'b1);
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 5; i++) begin
      write = tbl[i].wr; addr = tbl[i].a; lfsrdin = tbl[i].wd;
      s_valid = tbl[i].sv; s_data = tbl[i].sd;
      tick();
      chk("tbl_m_valid", m_valid, tbl[i].exp_mv);
      chk("tbl_m_data",  m_data,  tbl[i].exp_md);
      if (i == 0) chk("tbl_dout_first", dout, 212'h1000);
    end
    idle();

    // 4-beat burst with three stall cycles
    sent = 0; got = 0; held = '0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      s_valid = (sent < 4);
      s_data  = 12'($urandom);
      m_ready = !(c >= 1 && c <= 3);
      if (s_valid && (!m_mv || m_ready)) sent++;
      if (m_valid && m_ready) got++;
      tick();
      if (c == 0) held = m_md;
      if (c >= 1 && c <= 3) begin
        chk("stall_s_ready", s_ready, 1'b0);
        chk("stall_m_data", m_data, held);
      end
    end
    chk("burst_consumed", 32'(got), 32'd4);
    chk("burst_sent", 32'(sent), 32'd4);
    idle(); m_ready = 1'b1;

    // auto reseed every 4 beats
    write = 1'b1; addr = 12'h0e5; lfsrdin = 32'h2; tick();
    addr = 12'h0e4; lfsrdin = 32'h00080000; tick();
    write = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      s_valid = 1'b1; s_data = 12'h000;
      read = (b >= 4); addr = 12'h0e6;
      tick();
      if (b == 1) chk("reseed_beat1", m_data, 12'h001);
      if (b == 4) chk("reseed_dout", dout, SH);
      if (b == 5) chk("reseed_beat5", m_data, 12'h001);
`ifdef LFSR_SCRAMBLER_READBACK_EN
      if (b == 4) chk("beatcnt_3", rdata, 32'd3);
      if (b == 5) chk("beatcnt_0", rdata, 32'd0);
`endif
    end
    idle();
    write = 1'b1; addr = 12'h0e5; lfsrdin = 32'h0; tick(); idle();

    // frame_start together with an accepted beat
    for (int b = 0; b < 3; b++) begin
      s_valid = 1'b1; s_data = 12'($urandom); frame_start = (b == 2);
      tick();
    end
    chk("fs_dout", dout, SH);
    idle();

    // bypass, then reset while an output beat is held
    write = 1'b1; addr = 12'h0e5; lfsrdin = 32'h1; tick(); idle();
    s_valid = 1'b1; s_data = 12'h5A5; tick();
    chk("bypass_data", m_data, 12'h5A5);
    chk("bypass_frozen", dout, SH);
    s_data = 12'h3C3; m_ready = 1'b0; tick();
    chk("held_valid", m_valid, 1'b1);
    s_valid = 1'b0; rst_n = 1'b0; tick();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_dout", dout, SEED);
    rst_n = 1'b1; m_ready = 1'b1; read = 1'b1; addr = 12'h0e5; tick();
    chk("rst_rdata_ctrl", rdata, 32'd0);
    idle();

    // randomized run against the model
    for (int r = 0; r < 600; r++) begin
      write       = ($urandom_range(0, 7) == 0);
      addr        = 12'h0de + 12'($urandom_range(0, 9));
      lfsrdin     = $urandom;
      read        = ($urandom_range(0, 2) == 0);
      frame_start = ($urandom_range(0, 15) == 0);
      s_valid     = ($urandom_range(0, 3) != 0);
      s_data      = 12'($urandom);
      m_ready     = ($urandom_range(0, 3) != 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      tick();
    end
    idle(); rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
